// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port frame VRAM between the VGA display
// fetch path and the vector CPU load/store path.
//   - Display reads win over ordinary CPU traffic. A display request that
//     loses is parked in a one-entry deferral buffer and served next.
//   - A saturating wait counter forces a CPU grant after MAX_CPU_WAIT
//     consecutive losses, so the CPU always makes progress.
//   - Every issued read carries a two-stage tag {disp, cpu_rd, out_of_range}
//     that steers the VRAM read data back to the right requester, in order.
//   - Out-of-range addresses (>= DEPTH) are granted and use the slot, but
//     never strobe the VRAM: writes vanish and reads return zeros.
module vram_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 48,
    parameter int DEPTH        = 10923,
    parameter int MAX_CPU_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [5:0]        cpu_be,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [5:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       disp_drop_cnt
);

    localparam int                LANES    = DATA_W / 8;
    localparam int                WAIT_W   = $clog2(MAX_CPU_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_CPU_WAIT);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

    // Which requester owns the VRAM slot in the current cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_CPU  = 2'd1,
        SRC_PEND = 2'd2,
        SRC_DISP = 2'd3
    } src_e;

    // Arbitration state
    logic              r_pend_valid;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [15:0]       r_drop_cnt;

    // Issue registers (drive the VRAM directly)
    logic              r_mem_en;
    logic              r_mem_we;
    logic [5:0]        r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    // Read tag pipe: stage 1 aligns with mem_en, stage 2 with mem_rdata
    logic              r_tag1_disp;
    logic              r_tag1_cpu;
    logic              r_tag1_oor;
    logic              r_tag2_disp;
    logic              r_tag2_cpu;
    logic              r_tag2_oor;

    // Return registers
    logic              r_disp_valid;
    logic [DATA_W-1:0] r_disp_data;
    logic              r_cpu_rvalid;
    logic [DATA_W-1:0] r_cpu_rdata;

    // Combinational decision signals
    src_e              w_src;
    logic              w_force;
    logic [ADDR_W-1:0] w_iss_addr;
    logic              w_iss_in_range;
    logic              w_iss_write;
    logic              w_iss_disp;
    logic              w_iss_cpu_rd;
    logic              w_pend_valid_next;
    logic [ADDR_W-1:0] w_pend_addr_next;
    logic              w_drop;
    logic [WAIT_W-1:0] w_wait_cnt_next;
    logic [DATA_W-1:0] w_ret_data;

    // Pick the slot owner: forced CPU, then pending display, then new
    // display, then ordinary CPU. Nothing wins while reset is asserted.
    always_comb begin
        w_src   = SRC_NONE;
        w_force = cpu_req && (r_wait_cnt == WAIT_MAX);
        if (!rst_n) begin
            w_src = SRC_NONE;
        end else if (w_force) begin
            w_src = SRC_CPU;
        end else if (r_pend_valid) begin
            w_src = SRC_PEND;
        end else if (disp_req) begin
            w_src = SRC_DISP;
        end else if (cpu_req) begin
            w_src = SRC_CPU;
        end
    end

    assign cpu_gnt = (w_src == SRC_CPU);

    // Build the access that will be launched at the next edge.
    always_comb begin
        w_iss_addr = disp_addr;
        case (w_src)
            SRC_CPU:  w_iss_addr = cpu_addr;
            SRC_PEND: w_iss_addr = r_pend_addr;
            default:  w_iss_addr = disp_addr;
        endcase
        w_iss_in_range = (w_iss_addr < DEPTH_A);
        w_iss_write    = (w_src == SRC_CPU) && cpu_we;
        w_iss_disp     = (w_src == SRC_PEND) || (w_src == SRC_DISP);
        w_iss_cpu_rd   = (w_src == SRC_CPU) && !cpu_we;
    end

    // Deferral buffer and wait counter next-state. A losing display request
    // takes the buffer if it is empty or being drained this cycle; otherwise
    // (only possible on a forced CPU cycle) the new request is dropped.
    always_comb begin
        w_pend_valid_next = r_pend_valid;
        w_pend_addr_next  = r_pend_addr;
        w_drop            = 1'b0;
        w_wait_cnt_next   = '0;

        if (w_src == SRC_PEND) begin
            w_pend_valid_next = 1'b0;
        end
        if (rst_n && disp_req && (w_src != SRC_DISP)) begin
            if (!r_pend_valid || (w_src == SRC_PEND)) begin
                w_pend_valid_next = 1'b1;
                w_pend_addr_next  = disp_addr;
            end else begin
                w_drop = 1'b1;
            end
        end

        if (cpu_req && !cpu_gnt) begin
            w_wait_cnt_next = (r_wait_cnt == WAIT_MAX) ? r_wait_cnt
                                                       : r_wait_cnt + 1'b1;
        end
    end

    // Arbitration state: deferral entry, CPU wait counter, drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_wait_cnt   <= '0;
            r_drop_cnt   <= '0;
        end else begin
            r_pend_valid <= w_pend_valid_next;
            r_pend_addr  <= w_pend_addr_next;
            r_wait_cnt   <= w_wait_cnt_next;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // Launch the winning access onto the VRAM strobes; idle cycles only
    // drop mem_en and leave the other strobes where they were.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_en <= 1'b0;
            if (w_src != SRC_NONE) begin
                r_mem_en   <= w_iss_in_range;
                r_mem_we   <= w_iss_write;
                r_mem_be   <= w_iss_write ? cpu_be : 6'b0;
                r_mem_addr <= w_iss_addr;
                if (w_src == SRC_CPU) begin
                    r_mem_wdata <= cpu_wdata;
                end
            end
        end
    end

    // Tag pipe follows each read so the data returns to its owner; the
    // out-of-range flag replaces the (never fetched) data with zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag1_disp <= 1'b0;
            r_tag1_cpu  <= 1'b0;
            r_tag1_oor  <= 1'b0;
            r_tag2_disp <= 1'b0;
            r_tag2_cpu  <= 1'b0;
            r_tag2_oor  <= 1'b0;
        end else begin
            r_tag1_disp <= w_iss_disp;
            r_tag1_cpu  <= w_iss_cpu_rd;
            r_tag1_oor  <= (w_iss_disp || w_iss_cpu_rd) && !w_iss_in_range;
            r_tag2_disp <= r_tag1_disp;
            r_tag2_cpu  <= r_tag1_cpu;
            r_tag2_oor  <= r_tag1_oor;
        end
    end

    // Per-lane zeroing of the returned word for out-of-range reads.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_ret_lane
            assign w_ret_data[8*gi +: 8] = r_tag2_oor ? 8'h00
                                                      : mem_rdata[8*gi +: 8];
        end
    endgenerate

    // Register returned data into the owning requester's output; data
    // registers hold while their valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_valid <= 1'b0;
            r_disp_data  <= '0;
            r_cpu_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
        end else begin
            r_disp_valid <= r_tag2_disp;
            r_cpu_rvalid <= r_tag2_cpu;
            if (r_tag2_disp) begin
                r_disp_data <= w_ret_data;
            end
            if (r_tag2_cpu) begin
                r_cpu_rdata <= w_ret_data;
            end
        end
    end

    assign mem_en        = r_mem_en;
    assign mem_we        = r_mem_we;
    assign mem_be        = r_mem_be;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign disp_valid    = r_disp_valid;
    assign disp_data     = r_disp_data;
    assign cpu_rvalid    = r_cpu_rvalid;
    assign cpu_rdata     = r_cpu_rdata;
    assign disp_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a VRAM model answers the DUT's strobes, a
// behavioural reference (priority list, deferral queue, shadow memory)
// predicts grants and responses into queues, and a monitor checks them.
module tb_vram_arbiter;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 48;
    localparam int DEPTH  = 10923;
    localparam int MAXW   = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              disp_req = 1'b0;
    logic [ADDR_W-1:0] disp_addr = '0;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [5:0]        cpu_be = '0;
    logic              cpu_gnt;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              mem_en;
    logic              mem_we;
    logic [5:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [15:0]       disp_drop_cnt;

    always #5 clk = ~clk;

    vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_CPU_WAIT(MAXW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_gnt(cpu_gnt),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .disp_drop_cnt(disp_drop_cnt)
    );

    int     n_chk = 0;
    int     n_fail = 0;
    longint cyc = 0;

    logic [DATA_W-1:0] vram    [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];

    typedef struct { longint due; logic [DATA_W-1:0] data; } rsp_t;
    typedef struct { longint due; logic en; logic [ADDR_W-1:0] addr; logic we; logic [5:0] be; } iss_t;
    rsp_t disp_q[$];
    rsp_t cpu_q[$];
    iss_t iss_q[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(int i);
        logic [31:0] v;
        v = i;
        return {v[15:0] ^ 16'hA5A5, 16'(v * 3 + 1), ~v[15:0]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // VRAM model: registered read, byte-lane writes
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int l = 0; l < 6; l++)
                    if (mem_be[l]) vram[mem_addr][8*l +: 8] <= mem_wdata[8*l +: 8];
            end else begin
                mem_rdata <= vram[mem_addr];
            end
        end
    end

    // Reference model, evaluated once per cycle on stable inputs
    logic [ADDR_W-1:0] m_pend[$];
    int                m_wait = 0;
    int                m_drop = 0;
    int                m_src;
    logic [ADDR_W-1:0] m_a;
    logic              m_in;
    logic              m_wr;
    logic [DATA_W-1:0] m_d;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_pend.delete();
            m_wait = 0;
            m_drop = 0;
            disp_q.delete();
            cpu_q.delete();
            iss_q.delete();
        end else begin
            // 0 none, 1 cpu, 2 pending display, 3 new display
            if (cpu_req && m_wait == MAXW)   m_src = 1;
            else if (m_pend.size() != 0)     m_src = 2;
            else if (disp_req)               m_src = 3;
            else if (cpu_req)                m_src = 1;
            else                             m_src = 0;

            chk("cpu_gnt", 64'(cpu_gnt), 64'(m_src == 1));
            chk("drop_cnt", 64'(disp_drop_cnt), 64'(m_drop));

            if (m_src != 0) begin
                m_a  = (m_src == 1) ? cpu_addr : (m_src == 2) ? m_pend[0] : disp_addr;
                m_in = (int'(m_a) < DEPTH);
                m_wr = (m_src == 1) && cpu_we;
                iss_q.push_back('{due: cyc + 1, en: m_in, addr: m_a, we: m_wr,
                                  be: (m_wr ? cpu_be : 6'b0)});
                if (!m_wr) begin
                    m_d = m_in ? ref_mem[m_a] : '0;
                    if (m_src == 1) cpu_q.push_back('{due: cyc + 3, data: m_d});
                    else            disp_q.push_back('{due: cyc + 3, data: m_d});
                end else if (m_in) begin
                    for (int l = 0; l < 6; l++)
                        if (cpu_be[l]) ref_mem[m_a][8*l +: 8] = cpu_wdata[8*l +: 8];
                end
            end

            if (m_src == 2) void'(m_pend.pop_front());
            if (disp_req && m_src != 3) begin
                if (m_pend.size() == 0)  m_pend.push_back(disp_addr);
                else if (m_drop < 65535) m_drop++;
            end

            if (cpu_req && m_src != 1) m_wait = (m_wait < MAXW) ? m_wait + 1 : m_wait;
            else                       m_wait = 0;
        end
    end

    // Monitor: pops expectations when the DUT presents responses/strobes
    rsp_t r;
    iss_t e;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs_zero",
                64'(|{disp_valid, cpu_rvalid, mem_en, mem_we, mem_be, cpu_gnt,
                      mem_addr, mem_wdata, disp_data, cpu_rdata, disp_drop_cnt}), 64'd0);
        end else begin
            if (disp_valid || cpu_rvalid)
                chk("valid_exclusive", 64'(disp_valid && cpu_rvalid), 64'd0);

            if (disp_valid) begin
                if (disp_q.size() == 0) chk("disp_unexpected_valid", 64'(disp_valid), 64'd0);
                else begin
                    r = disp_q.pop_front();
                    chk("disp_latency", 64'(cyc), 64'(r.due));
                    chk("disp_data", 64'(disp_data), 64'(r.data));
                end
            end else if (disp_q.size() != 0 && disp_q[0].due <= cyc) begin
                r = disp_q.pop_front();
                chk("disp_missing_valid", 64'(disp_valid), 64'd1);
            end

            if (cpu_rvalid) begin
                if (cpu_q.size() == 0) chk("cpu_unexpected_rvalid", 64'(cpu_rvalid), 64'd0);
                else begin
                    r = cpu_q.pop_front();
                    chk("cpu_latency", 64'(cyc), 64'(r.due));
                    chk("cpu_rdata", 64'(cpu_rdata), 64'(r.data));
                end
            end else if (cpu_q.size() != 0 && cpu_q[0].due <= cyc) begin
                r = cpu_q.pop_front();
                chk("cpu_missing_rvalid", 64'(cpu_rvalid), 64'd1);
            end

            if (iss_q.size() != 0 && iss_q[0].due == cyc) begin
                e = iss_q.pop_front();
                chk("mem_en", 64'(mem_en), 64'(e.en));
                chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                if (e.en) begin
                    chk("mem_we", 64'(mem_we), 64'(e.we));
                    chk("mem_be", 64'(mem_be), 64'(e.be));
                end
            end else begin
                chk("mem_idle_en", 64'(mem_en), 64'd0);
            end
        end
    end

    // Stimulus helpers
    bit gnt_s;

    task automatic step();
        @(negedge clk);
        gnt_s = cpu_req && cpu_gnt;
        @(posedge clk);
        #1;
        if (gnt_s) cpu_req = 1'b0;
        disp_req = 1'b0;
    endtask

    task automatic cpu_op(bit we, int addr, logic [5:0] be, logic [DATA_W-1:0] wd);
        cpu_we    = we;
        cpu_addr  = ADDR_W'(addr);
        cpu_be    = be;
        cpu_wdata = wd;
        cpu_req   = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (gnt_s) return;
        end
        chk("cpu_grant_timeout", 64'(gnt_s), 64'd1);
        cpu_req = 1'b0;
    endtask

    function automatic logic [ADDR_W-1:0] rnd_addr();
        int sel;
        sel = $urandom_range(0, 19);
        if (sel == 0) return ADDR_W'(DEPTH + $urandom_range(0, 100));
        if (sel == 1) return 17'h1FFFF;
        return ADDR_W'($urandom_range(0, 63));
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            vram[i]    = pat(i);
            ref_mem[i] = pat(i);
        end
        vram[16]    = 48'h0A0B0C0D0E0F;
        ref_mem[16] = 48'h0A0B0C0D0E0F;

        // Reset held with random inputs
        #2 rst_n = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            disp_req  = 1'($urandom);
            disp_addr = ADDR_W'($urandom);
            cpu_req   = 1'($urandom);
            cpu_we    = 1'($urandom);
            cpu_addr  = ADDR_W'($urandom);
            cpu_be    = 6'($urandom);
            cpu_wdata = {$urandom, $urandom};
        end
        disp_req = 1'b0;
        cpu_req  = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) step();

        // Display only
        disp_addr = 17'h00010;
        disp_req  = 1'b1;
        step();
        repeat (5) step();

        // CPU write then read back
        cpu_op(1'b1, 5, 6'b000011, 48'h111111112222);
        repeat (3) step();
        cpu_op(1'b0, 5, 6'b0, '0);
        repeat (5) step();

        // Starvation and drops: display every cycle, CPU always requesting
        cpu_we   = 1'b0;
        cpu_addr = 17'd7;
        cpu_req  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            disp_req  = 1'b1;
            disp_addr = ADDR_W'(k);
            step();
            if (gnt_s) begin
                cpu_we   = 1'($urandom);
                cpu_addr = ADDR_W'($urandom_range(0, 63));
                cpu_be   = 6'($urandom);
                cpu_wdata = {$urandom, $urandom};
                cpu_req  = 1'b1;
            end
        end
        cpu_req = 1'b0;
        repeat (8) step();

        // Out of range
        cpu_op(1'b0, DEPTH, 6'b0, '0);
        repeat (4) step();
        cpu_op(1'b1, 'h1FFFF, 6'h3F, 48'hDEADBEEFCAFE);
        repeat (4) step();

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            step();
            if (!cpu_req && $urandom_range(0, 99) < 40) begin
                cpu_we    = 1'($urandom);
                cpu_addr  = rnd_addr();
                cpu_be    = 6'($urandom);
                cpu_wdata = {$urandom, $urandom};
                cpu_req   = 1'b1;
            end
            disp_req  = ($urandom_range(0, 99) < 45);
            disp_addr = rnd_addr();
        end
        disp_req = 1'b0;
        cpu_req  = 1'b0;
        repeat (8) step();

        // Reset with a read in flight: nothing may come out afterwards
        cpu_op(1'b0, 3, 6'b0, '0);
        step();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port frame VRAM (6 grey pixels × 8 bits per 48-bit word, 256×256 image = 10923 words) between two requesters: the VGA display fetch path and the vector CPU load/store path.
- Display reads have priority, and a one-entry deferral buffer protects them.
- A wait counter guarantees CPU forward progress.
- Read data is returned in order to each requester through a tagged pipeline.

Parameters:
- ADDR_W, 17, word address width.
- DATA_W, 48, word width (6 lanes × 8 bits).
- DEPTH, 10923, number of valid VRAM words; addresses ≥ DEPTH are out of range.
- MAX_CPU_WAIT, 4, number of consecutive cycles a CPU request may lose before it is forced.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- disp_req  in  1  display read request, one-cycle pulse, no handshake
- disp_addr  in  ADDR_W  display word address
- disp_data  out  DATA_W  display read data
- disp_valid  out  1  disp_data valid, one cycle per accepted display request
- cpu_req  in  1  CPU request; held with stable fields until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  write data
- cpu_be  in  6  byte-lane write enables, bit i = bits [8i+7:8i]
- cpu_gnt  out  1  combinational; transfer on an edge with cpu_req && cpu_gnt
- cpu_rdata  out  DATA_W  CPU read data
- cpu_rvalid  out  1  cpu_rdata valid
- mem_en, mem_we  out  1  registered VRAM strobes
- mem_be  out  6  registered lane enables
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  VRAM read data, valid the cycle after mem_en
- disp_drop_cnt  out  16  saturating count of dropped display requests

Behaviour:
- Reset (async assert, sync release):
  - All outputs, the pending buffer, the tag pipeline and the wait counter clear to 0.
  - Reads in flight at reset are discarded; no valid pulse follows reset release.
- Per-cycle decision, with force = cpu_req && (wait_cnt == MAX_CPU_WAIT). Priority, highest first:
  1. force → CPU
  2. pending → pending display
  3. disp_req → display
  4. cpu_req → CPU
- cpu_gnt = 1 exactly when the CPU wins the cycle.
- Deferral: a disp_req that does not win is captured into the pending register (address held).
  - If the pending entry is served in the same cycle as a new disp_req, the new request refills pending.
  - If pending is occupied and not served (force cycle) and a new disp_req arrives, the new request is dropped, pending is kept, and disp_drop_cnt increments (saturates at 0xFFFF).
- wait_cnt:
  - Increments, saturating at MAX_CPU_WAIT, on cycles with cpu_req && !cpu_gnt.
  - Clears on a grant or on any cycle with !cpu_req.
- Issue: the winning access drives mem_* on the following cycle.
  - mem_en = 1 only for in-range addresses (addr < DEPTH).
  - CPU writes use mem_we = 1 and mem_be = cpu_be. Reads use mem_we = 0 and mem_be = 0.
  - With no winner, mem_en = 0 and other mem_* hold their previous values.
- Out-of-range access:
  - Still granted and still occupies the slot.
  - A write is silently discarded.
  - A read returns all zeros with normal timing.
- Return path:
  - A 2-stage tag pipe {disp, cpu_rd} follows each issued read.
  - mem_rdata (or zero for out-of-range) is registered into disp_data or cpu_rdata with the matching valid.
- Latency: request edge T → mem_en high in cycle T+1 → data valid in cycle T+3.
  - Direct display read: 3 cycles.
  - Deferred display read: 4 cycles (or more if chained).
  - CPU read: 3 cycles after the grant edge.
  - Writes produce no response.
- Ordering: display responses are returned in request order. At most one of disp_valid and cpu_rvalid is high per cycle.
- Data registers hold their last value while the corresponding valid is low.

Test Plan:
- Reset/idle: hold rst_n = 0 with random inputs → all outputs 0. Release with no requests → mem_en stays 0 and no valid pulses.
- Display only: disp_req pulse, addr 0x00010, mem_rdata = 0x0A0B0C0D0E0F → mem_en high at T+1 with mem_addr 0x00010. disp_valid high at T+3 with that data.
- CPU write then read: write addr 5, be = 6'b000011, wdata = 0x111111112222 → mem_we = 1, mem_be = 0x03. Read addr 5 → cpu_rvalid high 3 cycles after the grant.
- Starvation: cpu_req held with disp_req every cycle → cpu_gnt low for 4 cycles, then high in the 5th. The colliding disp_req goes to pending and is served next, with disp_valid 4 cycles after it.
- Drop: MAX_CPU_WAIT = 1, disp_req every cycle with cpu_req always asserted → a force cycle eventually hits with pending full. disp_drop_cnt increments by 1 per such cycle, and the surviving disp_valid outputs stay in order.
- Out of range: CPU read addr 10923 → cpu_gnt = 1, mem_en = 0, cpu_rvalid at T+3 with data 0. Write addr 0x1FFFF → no mem_en. Assert rst_n low with a read in flight → no valid after release.
